// File: rtl/fifo_pkg.sv
// Shared constants for the 16x8 synchronous FIFO and its stream reader.
//   FIFO_WIDTH        data width of the FIFO and reader
//   FIFO_DEPTH        FIFO storage entries
//   FIFO_READ_LATENCY cycles from read strobe to valid read data
//   READER_DEPTH      reader skid-buffer entries
package fifo_pkg;

    localparam int FIFO_WIDTH        = 8;
    localparam int FIFO_DEPTH        = 16;
    localparam int FIFO_READ_LATENCY = 1;
    localparam int READER_DEPTH      = 3;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

    // Pointer width for a circular buffer; never narrower than one bit.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// DEPTH-entry circular buffer with push/pop, occupancy and registered head.
//   clock, reset_n   rising-edge clock, async active-low reset
//   push, push_data  write push_data at tail
//   pop              advance head (ignored when empty)
//   occ              current occupancy, 0..DEPTH
//   head_data        word at head, straight from storage registers
module skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = READER_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic [WIDTH-1:0]           head_data
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok    = pop && (occ != '0);
    assign head_data = mem[head];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= next_ptr(tail);
            end
            if (pop_ok) begin
                head <= next_ptr(head);
            end
            case ({push, pop_ok})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Consumer-side adapter for the 16x8 FIFO read port: issues active-low read
// strobes only when the FIFO has data and buffer room is guaranteed, captures
// the one-cycle-latency read data and presents it on a valid/ready stream.
//   clock, reset_n  rising-edge clock, async active-low reset
//   enable          gates new reads; in-flight data is still captured
//   fifo_empty      FIFO empty flag
//   fifo_data       FIFO registered read data
//   fifo_read_n     active-low read strobe to the FIFO
//   m_valid/m_data  stream output (buffer head)
//   m_ready         downstream accept
//   words_out       wrapping count of accepted words
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = READER_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read_n,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [15:0]      words_out
);

    localparam int OW = $clog2(DEPTH + 1);

    logic          inflight;
    logic [OW-1:0] occ;
    logic [OW:0]   committed;
    logic          issue;
    logic          pop;

    // Words already owed a buffer slot: stored plus the one arriving now.
    // Issuing only below DEPTH keeps occ + inflight <= DEPTH, so the
    // buffer can never overflow and m_ready never reaches the FIFO port.
    assign committed   = {1'b0, occ} + (OW+1)'(inflight);
    assign issue       = enable && !fifo_empty && (committed < (OW+1)'(DEPTH));
    assign fifo_read_n = !issue;

    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;

    skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_skid_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight  <= 1'b0;
            words_out <= '0;
        end else begin
            inflight <= issue;
            if (pop) begin
                words_out <= words_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        m_ready = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_read_n;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [15:0] words_out;

    logic        wr_en   = 1'b0;
    logic [7:0]  wr_data = 8'h00;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fifo_stream_reader dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_n (fifo_read_n),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .words_out   (words_out)
    );

    // Behavioural FIFO plus reference bookkeeping: expected output order is
    // simply the write order; outstanding = words read - words accepted.
    logic [7:0]  fmem [16];
    int          fcount, frd, fwr;
    int          rd_cnt, acc_cnt;
    logic [15:0] exp_wo;
    logic [7:0]  exp_q [$];

    assign fifo_empty = (fcount == 0);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcount    <= 0;
            frd       <= 0;
            fwr       <= 0;
            fifo_data <= 8'h00;
            rd_cnt    <= 0;
            acc_cnt   <= 0;
            exp_wo    <= 16'h0000;
            exp_q.delete();
        end else begin
            if (wr_en) begin
                fmem[fwr] <= wr_data;
                fwr       <= (fwr + 1) % 16;
                exp_q.push_back(wr_data);
            end
            if (!fifo_read_n) begin
                fifo_data <= fmem[frd];
                frd       <= (frd + 1) % 16;
                rd_cnt    <= rd_cnt + 1;
            end
            fcount <= fcount + (wr_en ? 1 : 0) - (!fifo_read_n ? 1 : 0);
            if (m_valid && m_ready) begin
                acc_cnt <= acc_cnt + 1;
                exp_wo  <= exp_wo + 16'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (reset_n) begin
            chk("no_read_when_empty", 32'(fifo_empty && !fifo_read_n), 32'd0);
            chk("occ_plus_inflight_le_depth", 32'((rd_cnt - acc_cnt) <= READER_DEPTH), 32'd1);
            chk("words_out", 32'(words_out), 32'(exp_wo));
            if (m_valid && m_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("beat_data", 32'(m_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (exp_q.size() == 0 && !m_valid) done = 1'b1;
            else step();
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int a0, r0, nw;
        logic done;

        // Reset values
        #2;
        chk("rst_read_n", 32'(fifo_read_n), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_words_out", 32'(words_out), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Full-rate streaming of 0x10..0x1F
        m_ready = 1'b1;
        preload(16, 8'h10);
        a0 = acc_cnt;
        enable = 1'b1;
        #1;
        chk("first_strobe", 32'(fifo_read_n), 32'd0);
        step();
        chk("valid_after_1", 32'(m_valid), 32'd0);
        step();
        chk("valid_after_2", 32'(m_valid), 32'd1);
        chk("first_data", 32'(m_data), 32'h10);
        for (int i = 0; i < 16; i++) step();
        chk("stream_16_beats", 32'(acc_cnt - a0), 32'd16);
        chk("stream_done_valid", 32'(m_valid), 32'd0);
        chk("stream_words_out", 32'(words_out), 32'd16);
        chk("stream_idle_read_n", 32'(fifo_read_n), 32'd1);

        // Stall after the first word
        enable = 1'b0;
        preload(16, 8'h10);
        a0 = acc_cnt;
        enable = 1'b1;
        step();
        step();
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 2) begin
                chk("stall_read_n", 32'(fifo_read_n), 32'd1);
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'h11);
                chk("stall_buffered", 32'(rd_cnt - acc_cnt), 32'd3);
            end
        end
        m_ready = 1'b1;
        drain("stall_drain");
        chk("stall_total", 32'(acc_cnt - a0), 32'd16);
        chk("stall_words_out", 32'(words_out), 32'd32);

        // Enable dropped while a read is in flight
        enable = 1'b0;
        preload(6, 8'h40);
        enable = 1'b1;
        step();
        step();
        chk("en_strobe_active", 32'(fifo_read_n), 32'd0);
        r0 = rd_cnt;
        enable = 1'b0;
        #1;
        chk("en_drop_read_n", 32'(fifo_read_n), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en_off_no_reads", 32'(rd_cnt), 32'(r0));
        end
        chk("en_inflight_drained", 32'(acc_cnt), 32'(rd_cnt));
        chk("en_off_valid", 32'(m_valid), 32'd0);
        enable = 1'b1;
        drain("en_resume_drain");

        // Random writes and random backpressure
        nw = 0;
        a0 = acc_cnt;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (nw < 200 && fcount < 15 && ($urandom % 2) == 1) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                nw++;
            end else begin
                wr_en = 1'b0;
            end
            m_ready = 1'($urandom % 2);
            if (nw == 200 && !wr_en && exp_q.size() == 0 && !m_valid) done = 1'b1;
            else step();
        end
        wr_en = 1'b0;
        chk("rand_done", 32'(done), 32'd1);
        chk("rand_total", 32'(acc_cnt - a0), 32'd200);

        // Reset with two words buffered and one in flight
        m_ready = 1'b0;
        enable  = 1'b0;
        preload(5, 8'h60);
        enable = 1'b1;
        step();
        step();
        step();
        chk("pre_rst_outstanding", 32'(rd_cnt - acc_cnt), 32'd3);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_read_n", 32'(fifo_read_n), 32'd1);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'h00);
        chk("mid_rst_words_out", 32'(words_out), 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_read_n", 32'(fifo_read_n), 32'd1);
            chk("post_rst_valid", 32'(m_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Consumer-side adapter for the team's 16x8 synchronous FIFO read port. It issues active-low read strobes only when the FIFO is non-empty and buffer space is guaranteed, and captures the FIFO's registered, one-cycle-latency read data. It re-presents that data on a valid/ready stream output at full throughput. It sits between the FIFO and any downstream consumer that can stall, such as a serializer or packet builder.

## Interface
- WIDTH, 8, data width; must match the FIFO.
- DEPTH, 3, skid buffer entries; minimum 3 for one word per cycle without a ready-to-read combinational path.
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  when low, no new reads are issued; in-flight data is still captured.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WIDTH  FIFO registered read data.
- fifo_read_n  out  1  active-low read strobe to the FIFO.
- m_valid  out  1  output word available.
- m_data  out  WIDTH  output word (buffer head).
- m_ready  in  1  downstream accepts m_data when m_valid && m_ready.
- words_out  out  16  count of words accepted downstream; wraps 0xFFFF→0x0000.

## Operation
- State registers:
  - occ: buffer occupancy, 0..DEPTH.
  - inflight: 1 if a read was issued last cycle.
  - head/tail pointers: mod DEPTH.
  - words_out.
- Issue rule: fifo_read_n = 0 iff enable && !fifo_empty && (occ + inflight) < DEPTH.
  - Combinational from registered state plus fifo_empty and enable only.
  - Never depends on m_ready.
- fifo_read_n is never low while fifo_empty = 1. The FIFO's count logic does not gate reads on empty, so this block guarantees it.
- Capture: when inflight = 1, fifo_data is written at tail on that edge and tail advances.
- Pop: when m_valid && m_ready, head advances and words_out increments.
- Occupancy update: simultaneous capture and pop leaves occ unchanged; capture only gives occ+1; pop only gives occ−1.
- m_valid = (occ != 0). m_data = buffer[head], driven from registers.
- Overflow is impossible by construction: occ + inflight ≤ DEPTH is an invariant. The bench asserts it.
- enable deasserted mid-stream: at most one further word (the in-flight one) enters the buffer; buffered words still drain.
- Reset values:
  - fifo_read_n = 1, m_valid = 0, m_data = 0, words_out = 0.
  - occ, inflight and pointers = 0.
  - Buffer contents = 0.
- Reset mid-operation: the in-flight read and all buffered data are discarded. The FIFO is reset by the same reset_n, so no word is lost across the pair.

## Timing
- Cycle N: fifo_read_n = 0, sampled by the FIFO at edge N.
- Cycle N+1: fifo_data is valid and inflight = 1; the word is captured at edge N+1.
- Cycle N+2: m_valid = 1 (buffer was empty).
- Latency from FIFO read strobe to m_valid: 2 cycles. From fifo_empty falling (idle, enable = 1) to m_valid: 2 cycles.
- Steady state with m_ready = 1 and a non-empty FIFO: one read per cycle, occ = 1, inflight = 1, one word per cycle out.
- m_ready low: at most DEPTH − occ reads are still issued. fifo_read_n rises in the cycle occ + inflight reaches DEPTH.
- m_valid and m_data stay stable while m_valid && !m_ready.
- Pointer wrap: DEPTH − 1 → 0; no bubble at wrap.
- words_out updates on the edge the transfer completes.

## Structure
- Shared package `fifo_pkg`: FIFO_WIDTH = 8, FIFO_DEPTH = 16, FIFO_READ_LATENCY = 1, READER_DEPTH = 3; shared by the FIFO and this reader.
- One sub-module, `skid_buf`: DEPTH-entry circular buffer with push/pop, occupancy and head data.
- The top level contains the issue logic, inflight flag and words_out.

## Test plan
- Reset → fifo_read_n = 1, m_valid = 0, m_data = 0x00, words_out = 0.
- FIFO preloaded with 0x10..0x1F, m_ready = 1:
  - first m_valid 2 cycles after the first strobe;
  - 16 consecutive beats 0x10..0x1F;
  - words_out = 16;
  - fifo_read_n never low with fifo_empty = 1.
- Same preload, m_ready low for 10 cycles after the first word:
  - exactly 3 words buffered;
  - fifo_read_n = 1 while stalled;
  - on release, order 0x10.. is preserved with no duplicates or gaps.
- Random m_ready at 50% over 200 words with random FIFO writes:
  - output equals the input order;
  - occ + inflight ≤ 3 every cycle;
  - the pointer wrap is exercised.
- enable dropped in the cycle of a strobe → exactly one more word is captured and no further strobes are issued; re-enable resumes with the next FIFO word.
- reset_n pulsed low with 2 words buffered and 1 in flight → all outputs return to reset values immediately; after release, the empty FIFO produces no strobes.
